button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Conditions the raw push-buttons on the board before they reach the operand/opcode load stage.
- Each button goes through a 2-FF synchroniser, then a debounce filter.
- Each qualified press produces exactly one single-cycle pulse.
- A serialiser guarantees at most one pulse per cycle, so the load stage sees only clean one-hot codes (3'd1 = load A, 3'd2 = load B, 3'd4 = load operation), one per press.

Parameters:
- NB_BUTTONS, 3: number of button inputs/pulse outputs.
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples required to accept a level change. 10 ms at 100 MHz; minimum legal value 2.
- NB_CNT, $clog2(DEBOUNCE_CYCLES+1): debounce counter width (derived, not overridden).

Ports:
- i_clock  in  1  system clock; all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_buttons  in  NB_BUTTONS  raw asynchronous button levels, 1 = pressed
- o_pulses  out  NB_BUTTONS  registered press pulses; at most one bit high per cycle; each high for exactly 1 cycle
- o_pending  out  1  high while any accepted press is waiting behind the serialiser

Behaviour:
- Clocking and reset:
  - One clock (i_clock).
  - Reset is synchronous and active-high (i_reset).
  - While i_reset=1 at an edge, the following clear to 0: sync flops, counters, pending flags, o_pulses, o_pending. All FSMs go to IDLE.
- Synchroniser:
  - 2 flops per bit; sync2[k] is the only value the filter sees.
- Per-button FSM (states IDLE, WAIT_HIGH, PRESSED, WAIT_LOW; counter cnt):
  - IDLE: sync2=1 -> WAIT_HIGH, cnt=1; else stay.
  - WAIT_HIGH:
    - sync2=0 -> IDLE, cnt=0 (glitch rejected).
    - sync2=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, cnt=0, raise accept[k] for this cycle.
    - Otherwise cnt+1.
  - PRESSED: sync2=0 -> WAIT_LOW, cnt=1; else stay.
  - WAIT_LOW:
    - sync2=1 -> PRESSED, cnt=0.
    - sync2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt=0.
    - Otherwise cnt+1.
    - Release never produces a pulse.
  - cnt never wraps; it saturates at the qualifying value.
- Serialiser:
  - accept[k] sets pending[k].
  - Each cycle, the lowest-index set pending bit is issued: o_pulses gets that one-hot bit on the next edge, and that pending bit clears.
  - A new accept on a bit already pending is merged (only one pulse issued).
  - Simultaneous accept and issue on the same bit: the issue wins and the new accept re-sets pending (second pulse follows). This cannot occur within DEBOUNCE_CYCLES≥2 but must be coded.
  - o_pending = OR of pending flags after the issue.
- Latency:
  - Raw button goes high before edge E0 and stays high.
  - o_pulses[k] is high in the cycle after edge E0+DEBOUNCE_CYCLES+2 (2 sync + DEBOUNCE_CYCLES filter + 1 output register), when uncontended.
  - Each contended bit adds 1 cycle per lower-index bit issued ahead of it.
- Button held through reset deassert: the FSM starts in IDLE, sees a high level, and a fresh pulse is issued after the full latency.
- Held button: one pulse only; re-arm requires a qualified release.

Optional Feature:
- Macro BUTTON_LEVEL_OUT_EN.
- Defined: adds output port o_levels [NB_BUTTONS-1:0].
  - Registered debounced level: bit k = 1 in PRESSED/WAIT_LOW, 0 in IDLE/WAIT_HIGH.
  - Reset value 0.
  - Intended for board LEDs.
- Undefined: port absent; no extra flops; all other behaviour identical.

Decomposition:
- Shared package button_pkg:
  - FSM state typedef/localparams: IDLE=2'd0, WAIT_HIGH=2'd1, PRESSED=2'd2, WAIT_LOW=2'd3.
  - Button index constants BTN_LOAD_A=0, BTN_LOAD_B=1, BTN_LOAD_OP=2.
- Sub-module button_debounce:
  - Holds one bit's synchroniser, FSM and counter.
  - Outputs accept and level.
  - Instantiated NB_BUTTONS times via generate.
- The serialiser/pending logic lives in button_conditioner.

Test Plan (DEBOUNCE_CYCLES=4):
1. i_buttons=3'b001 from edge 0, held 20 cycles -> o_pulses=3'b001 for exactly one cycle, after edge 6; no further pulse while held.
2. i_buttons[1] toggled 1,1,0,1,1,0 on successive cycles -> o_pulses stays 0; then held high 6 cycles -> a single 3'b010 pulse.
3. i_buttons=3'b111 applied at edge 0 -> pulses 3'b001, 3'b010, 3'b100 in three consecutive cycles starting after edge 6. o_pending=1 during the first two pulse cycles and 0 with the last.
4. Press, release ≥6 cycles, press again on bit 2 -> two separate 3'b100 pulses. A release shorter than 4 stable samples -> only one pulse.
5. i_reset=1 for 2 cycles in the middle of WAIT_HIGH with the button held -> o_pulses=0 during reset; one pulse 7 cycles after the first post-reset edge; no duplicate.
6. With BUTTON_LEVEL_OUT_EN: press bit 0 -> o_levels[0] rises in the same cycle the FSM enters PRESSED, and falls 4 stable-low samples after release.

Source files
------------

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared constants for the push-button conditioning path
//
// Purpose: per-button debounce FSM state encoding and button index names
//          shared by button_debounce and button_conditioner.
// Ports:   none (package).
package button_pkg;

   // Debounce FSM states. Bit 1 set means the debounced level is "pressed".
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WAIT_HIGH = 2'd1;
   localparam logic [1:0] PRESSED   = 2'd2;
   localparam logic [1:0] WAIT_LOW  = 2'd3;

   // Button positions on i_buttons / o_pulses.
   localparam int BTN_LOAD_A  = 0;
   localparam int BTN_LOAD_B  = 1;
   localparam int BTN_LOAD_OP = 2;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - one button: 2-FF synchroniser plus debounce FSM
//
// Purpose: samples one raw asynchronous button, filters it through a
//          four-state debounce FSM and flags each qualified press.
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   synchronous, active-high reset
//   button in   raw asynchronous button level, 1 = pressed
//   accept out  high for the one cycle in which a press qualifies
//   level  out  debounced level (1 in PRESSED/WAIT_LOW), straight from the
//               state register
module button_debounce
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int NB_CNT          = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clock,
   input  logic reset,
   input  logic button,
   output logic accept,
   output logic level
);

   localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);
   localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

   logic              sync1;
   logic              sync2;
   logic [1:0]        state;
   logic [1:0]        state_next;
   logic [NB_CNT-1:0] cnt;
   logic [NB_CNT-1:0] cnt_next;

   // The counter includes the sample that started the WAIT_* state, so the
   // transition fires on the DEBOUNCE_CYCLES-th consecutive stable sample and
   // never counts past CNT_LAST.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (sync2) begin
               state_next = WAIT_HIGH;
               cnt_next   = CNT_ONE;
            end
         end
         WAIT_HIGH: begin
            if (!sync2) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = PRESSED;
               cnt_next   = '0;
               accept     = 1'b1;
            end else begin
               cnt_next = cnt + CNT_ONE;
            end
         end
         PRESSED: begin
            if (!sync2) begin
               state_next = WAIT_LOW;
               cnt_next   = CNT_ONE;
            end
         end
         WAIT_LOW: begin
            if (sync2) begin
               state_next = PRESSED;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CNT_ONE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         state <= IDLE;
         cnt   <= '0;
      end else begin
         sync1 <= button;
         sync2 <= sync1;
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   assign level = state[1];

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced, serialised one-hot press pulses
//
// Purpose: synchronises and debounces every push-button, then serialises the
//          qualified presses so the load stage sees at most one single-cycle
//          one-hot pulse per clock, one pulse per press.
// Ports:
//   i_clock   in   system clock, rising edge
//   i_reset   in   synchronous, active-high reset
//   i_buttons in   [NB_BUTTONS] raw asynchronous levels, 1 = pressed
//   o_pulses  out  [NB_BUTTONS] registered press pulses, at most one bit high
//   o_pending out  high while an accepted press waits behind the serialiser
//   o_levels  out  [NB_BUTTONS] debounced levels, only with BUTTON_LEVEL_OUT_EN
// Build option: define BUTTON_LEVEL_OUT_EN to add o_levels.
module button_conditioner
   import button_pkg::*;
#(
   parameter int  NB_BUTTONS      = 3,
   parameter int  DEBOUNCE_CYCLES = 1000000,
   localparam int NB_CNT          = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic [NB_BUTTONS-1:0] i_buttons,
   output logic [NB_BUTTONS-1:0] o_pulses,
   output logic                  o_pending
`ifdef BUTTON_LEVEL_OUT_EN
   ,
   output logic [NB_BUTTONS-1:0] o_levels
`endif
);

   logic [NB_BUTTONS-1:0] accept;
   logic [NB_BUTTONS-1:0] level;
   logic [NB_BUTTONS-1:0] pending;
   logic [NB_BUTTONS-1:0] issue;
   logic [NB_BUTTONS-1:0] pending_next;

   for (genvar k = 0; k < NB_BUTTONS; k++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .NB_CNT          (NB_CNT)
      ) u_debounce (
         .clock  (i_clock),
         .reset  (i_reset),
         .button (i_buttons[k]),
         .accept (accept[k]),
         .level  (level[k])
      );
   end

   // Lowest-index pending bit wins (two's-complement isolate-lowest-set).
   assign issue = pending & (~pending + NB_BUTTONS'(1));

   // Clearing the issued bit before OR-ing in accept means a fresh accept on
   // the bit being issued re-arms it, giving a second pulse; an accept on a
   // bit still waiting simply merges.
   assign pending_next = (pending & ~issue) | accept;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         pending  <= '0;
         o_pulses <= '0;
      end else begin
         pending  <= pending_next;
         o_pulses <= issue;
      end
   end

   assign o_pending = |pending;

`ifdef BUTTON_LEVEL_OUT_EN
   assign o_levels = level;
`else
   logic unused_level;
   assign unused_level = ^level;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

   localparam int NB = 3;
   localparam int DC = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] btn = '0;
   logic [NB-1:0] pulses;
   logic          pending;
`ifdef BUTTON_LEVEL_OUT_EN
   logic [NB-1:0] levels;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // Log index j holds outputs sampled just after edge j, where the input
   // value for edge j was applied by the j-th call of cycle().
   logic [NB-1:0] pulses_log [0:63];
   logic          pend_log   [0:63];
   logic [NB-1:0] levels_log [0:63];
   int            log_n;

   button_conditioner #(
      .NB_BUTTONS      (NB),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .i_clock   (clk),
      .i_reset   (rst),
      .i_buttons (btn),
      .o_pulses  (pulses),
      .o_pending (pending)
`ifdef BUTTON_LEVEL_OUT_EN
      ,
      .o_levels  (levels)
`endif
   );

   always #5 clk = ~clk;

   task automatic cycle(input logic [NB-1:0] b);
      btn = b;
      @(posedge clk);
      #1;
      if (log_n < 64) begin
         pulses_log[log_n] = pulses;
         pend_log[log_n]   = pending;
`ifdef BUTTON_LEVEL_OUT_EN
         levels_log[log_n] = levels;
`else
         levels_log[log_n] = '0;
`endif
      end
      log_n++;
   endtask

   task automatic cycles(input logic [NB-1:0] b, input int n);
      for (int i = 0; i < n; i++) cycle(b);
   endtask

   function automatic int count_pulses();
      int c = 0;
      for (int i = 0; i < log_n && i < 64; i++)
         if (pulses_log[i] != '0) c++;
      return c;
   endfunction

   function automatic int count_multi_hot();
      int c = 0;
      for (int i = 0; i < log_n && i < 64; i++)
         if ($countones(pulses_log[i]) > 1) c++;
      return c;
   endfunction

   task automatic test_reset();
      rst   = 1'b1;
      log_n = 0;
      cycles(3'b000, 2);
      cycles(3'b111, 3);
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (pulses_log[i] !== 3'b000 || pend_log[i] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out[%0d] pulses=%b pending=%b want 000/0", i, pulses_log[i], pend_log[i]);
         end
      end
      rst = 1'b0;
      cycles(3'b000, 8);
   endtask

   task automatic test_single_press();
      log_n = 0;
      cycles(3'b001, 20);
      n_cmp++;
      if (pulses_log[5] !== 3'b000 || pend_log[5] !== 1'b1) begin
         n_bad++;
         $display("FAIL single_edge5 pulses=%b pending=%b want 000/1", pulses_log[5], pend_log[5]);
      end
      n_cmp++;
      if (pulses_log[6] !== 3'b001 || pend_log[6] !== 1'b0) begin
         n_bad++;
         $display("FAIL single_edge6 pulses=%b pending=%b want 001/0", pulses_log[6], pend_log[6]);
      end
      n_cmp++;
      if (count_pulses() !== 1) begin
         n_bad++;
         $display("FAIL single_count got %0d want 1", count_pulses());
      end
      cycles(3'b000, 12);
   endtask

   task automatic test_glitch();
      log_n = 0;
      cycle(3'b010); cycle(3'b010); cycle(3'b000);
      cycle(3'b010); cycle(3'b010); cycle(3'b000);
      cycles(3'b010, 6);
      cycles(3'b000, 14);
      n_cmp++;
      if (pulses_log[12] !== 3'b010) begin
         n_bad++;
         $display("FAIL glitch_pulse12 got %b want 010", pulses_log[12]);
      end
      n_cmp++;
      if (count_pulses() !== 1) begin
         n_bad++;
         $display("FAIL glitch_count got %0d want 1", count_pulses());
      end
   endtask

   task automatic test_simultaneous();
      log_n = 0;
      cycles(3'b111, 12);
      n_cmp++;
      if (pulses_log[6] !== 3'b001 || pend_log[6] !== 1'b1) begin
         n_bad++;
         $display("FAIL simul_edge6 pulses=%b pending=%b want 001/1", pulses_log[6], pend_log[6]);
      end
      n_cmp++;
      if (pulses_log[7] !== 3'b010 || pend_log[7] !== 1'b1) begin
         n_bad++;
         $display("FAIL simul_edge7 pulses=%b pending=%b want 010/1", pulses_log[7], pend_log[7]);
      end
      n_cmp++;
      if (pulses_log[8] !== 3'b100 || pend_log[8] !== 1'b0) begin
         n_bad++;
         $display("FAIL simul_edge8 pulses=%b pending=%b want 100/0", pulses_log[8], pend_log[8]);
      end
      n_cmp++;
      if (count_pulses() !== 3 || count_multi_hot() !== 0) begin
         n_bad++;
         $display("FAIL simul_count pulses=%0d multi_hot=%0d want 3/0", count_pulses(), count_multi_hot());
      end
      cycles(3'b000, 12);
   endtask

   task automatic test_repress();
      log_n = 0;
      cycles(3'b100, 8);
      cycles(3'b000, 8);
      cycles(3'b100, 8);
      cycles(3'b000, 8);
      n_cmp++;
      if (pulses_log[6] !== 3'b100 || pulses_log[22] !== 3'b100) begin
         n_bad++;
         $display("FAIL repress_pulses got %b,%b want 100,100", pulses_log[6], pulses_log[22]);
      end
      n_cmp++;
      if (count_pulses() !== 2) begin
         n_bad++;
         $display("FAIL repress_count got %0d want 2", count_pulses());
      end
      log_n = 0;
      cycles(3'b100, 8);
      cycles(3'b000, 2);
      cycles(3'b100, 8);
      cycles(3'b000, 10);
      n_cmp++;
      if (count_pulses() !== 1) begin
         n_bad++;
         $display("FAIL short_release_count got %0d want 1", count_pulses());
      end
   endtask

   task automatic test_reset_mid_press();
      log_n = 0;
      cycles(3'b001, 4);
      rst = 1'b1;
      cycles(3'b001, 2);
      for (int i = 4; i < 6; i++) begin
         n_cmp++;
         if (pulses_log[i] !== 3'b000 || pend_log[i] !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_out[%0d] pulses=%b pending=%b want 000/0", i, pulses_log[i], pend_log[i]);
         end
      end
      rst   = 1'b0;
      log_n = 0;
      cycles(3'b001, 14);
      n_cmp++;
      if (pulses_log[5] !== 3'b000 || pulses_log[6] !== 3'b001) begin
         n_bad++;
         $display("FAIL midreset_pulse got %b,%b want 000,001", pulses_log[5], pulses_log[6]);
      end
      n_cmp++;
      if (count_pulses() !== 1) begin
         n_bad++;
         $display("FAIL midreset_count got %0d want 1", count_pulses());
      end
      cycles(3'b000, 12);
   endtask

`ifdef BUTTON_LEVEL_OUT_EN
   task automatic test_levels();
      log_n = 0;
      cycles(3'b001, 8);
      cycles(3'b000, 10);
      n_cmp++;
      if (levels_log[4] !== 3'b000 || levels_log[5] !== 3'b001) begin
         n_bad++;
         $display("FAIL level_rise got %b,%b want 000,001", levels_log[4], levels_log[5]);
      end
      n_cmp++;
      if (levels_log[12] !== 3'b001 || levels_log[13] !== 3'b000) begin
         n_bad++;
         $display("FAIL level_fall got %b,%b want 001,000", levels_log[12], levels_log[13]);
      end
   endtask
`endif

   initial begin
      log_n = 0;
      test_reset();
      test_single_press();
      test_glitch();
      test_simultaneous();
      test_repress();
      test_reset_mid_press();
`ifdef BUTTON_LEVEL_OUT_EN
      test_levels();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
